// File: rtl/hmmm_pad_bridge.sv
// hmmm_pad_bridge
// ---------------------------------------------------------------------------
// GPIO-side front end of the Hmmm core. Turns the pad programming protocol
// (address/data strobes on a shared 16-bit bus) into single-cycle program
// memory writes. Once the loader has been idle for IDLE_CYCLES it starts the
// core. While the core runs, its input/output requests become pad read/write
// handshakes, and halt is reported on the pads.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   pad_pgrm_addr/pad_pgrm_data address / data strobes (asynchronous pads)
//   pad_data_in                 shared bus input (asynchronous pads)
//   pad_data_out, pad_data_oeb  shared bus output value and active-low enable
//   pad_read, pad_write         input request / output valid to the host
//   pad_halt                    core halted indicator
//   mem_we, mem_addr, mem_wdata program memory write port
//   cpu_run                     core execution enable
//   cpu_in_req/data/valid       core input handshake
//   cpu_out_req/data/ack        core output handshake
//   cpu_halted                  core executed halt
// ---------------------------------------------------------------------------
module hmmm_pad_bridge #(
  parameter int IDLE_CYCLES = 32,
  parameter int IN_SETTLE   = 4,
  parameter int OUT_HOLD    = 4,
  parameter int ADDR_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              pad_pgrm_addr,
  input  logic              pad_pgrm_data,
  input  logic [15:0]       pad_data_in,
  output logic [15:0]       pad_data_out,
  output logic [15:0]       pad_data_oeb,
  output logic              pad_read,
  output logic              pad_write,
  output logic              pad_halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  input  logic              cpu_in_req,
  output logic [15:0]       cpu_in_data,
  output logic              cpu_in_valid,
  input  logic              cpu_out_req,
  input  logic [15:0]       cpu_out_data,
  output logic              cpu_out_ack,
  input  logic              cpu_halted
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int HS_MAX = (IN_SETTLE > OUT_HOLD) ? IN_SETTLE : OUT_HOLD;
  localparam int HS_W   = $clog2(HS_MAX + 1);

  localparam logic [IDLE_W-1:0] IDLE_TGT = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [HS_W-1:0]   IN_TGT   = HS_W'(IN_SETTLE);
  localparam logic [HS_W-1:0]   OUT_LAST = HS_W'(OUT_HOLD - 1);
  localparam logic [HS_W-1:0]   HS_ONE   = HS_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_IN_WAIT,
    S_OUT_DRIVE,
    S_HALTED
  } state_t;

  // Two-flop synchronizers; the third strobe flop holds the previous
  // synchronized value for rising-edge detection.
  logic        addr_s1, addr_s2, addr_s3;
  logic        data_s1, data_s2, data_s3;
  logic [15:0] bus_s1, bus_s2;
  logic        addr_edge, data_edge;

  assign addr_edge = addr_s2 & ~addr_s3;
  assign data_edge = data_s2 & ~data_s3;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_reg, addr_d, addr_sel;
  logic [IDLE_W-1:0]   idle_cnt, idle_d, idle_inc;
  logic                loaded, loaded_d;
  logic [HS_W-1:0]     hs_cnt, hs_d, hs_inc;

  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [15:0]         mem_wdata_d;
  logic [15:0]         pad_data_out_d;
  logic [15:0]         cpu_in_data_d;
  logic                cpu_in_valid_d;
  logic                cpu_out_ack_d;
  logic                pad_read_d, pad_write_d, pad_halt_d, cpu_run_d;

  // The bus is only ever driven while pad_write is high, and pad_write and
  // pad_read come from mutually exclusive states, so the bus can never be
  // driven while the host is asked to drive it.
  assign pad_data_oeb = {16{~pad_write}};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d        = state;
    addr_d         = addr_reg;
    addr_sel       = addr_reg;
    idle_d         = idle_cnt;
    idle_inc       = idle_cnt + IDLE_ONE;
    loaded_d       = loaded;
    hs_d           = hs_cnt;
    hs_inc         = hs_cnt + HS_ONE;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    pad_data_out_d = pad_data_out;
    cpu_in_data_d  = cpu_in_data;
    cpu_in_valid_d = 1'b0;
    cpu_out_ack_d  = 1'b0;

    case (state)
      S_LOAD: begin
        // An address edge in the same cycle as a data edge loads first,
        // so the write lands on the freshly loaded address.
        addr_sel = addr_edge ? bus_s2[ADDR_W-1:0] : addr_reg;
        addr_d   = addr_sel;
        if (data_edge) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_sel;
          mem_wdata_d = bus_s2;
          addr_d      = addr_sel + ADDR_ONE;
          loaded_d    = 1'b1;
        end
        if (addr_edge || data_edge) begin
          idle_d = '0;
        end else if (loaded) begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_TGT) state_d = S_RUN;
        end
      end

      S_RUN: begin
        // While a valid/ack pulse is out, the core may still be showing the
        // request it is about to drop; skip that cycle so one request is
        // never served twice.
        if (cpu_halted) begin
          state_d = S_HALTED;
        end else if (!cpu_in_valid && !cpu_out_ack) begin
          if (cpu_in_req) begin
            state_d = S_IN_WAIT;
            hs_d    = '0;
          end else if (cpu_out_req) begin
            state_d        = S_OUT_DRIVE;
            hs_d           = '0;
            pad_data_out_d = cpu_out_data;
            cpu_out_ack_d  = (OUT_LAST == '0);
          end
        end
      end

      S_IN_WAIT: begin
        hs_d = hs_inc;
        if (hs_inc == IN_TGT) begin
          cpu_in_data_d  = bus_s2;
          cpu_in_valid_d = 1'b1;
          state_d        = S_RUN;
        end
      end

      S_OUT_DRIVE: begin
        if (hs_cnt == OUT_LAST) begin
          state_d = S_RUN;
        end else begin
          hs_d          = hs_inc;
          cpu_out_ack_d = (hs_inc == OUT_LAST);
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: state_d = S_LOAD;
    endcase

    // Pad and run outputs are registered copies of the next-state decode so
    // the pads see clean, glitch-free levels.
    pad_read_d  = (state_d == S_IN_WAIT);
    pad_write_d = (state_d == S_OUT_DRIVE);
    pad_halt_d  = (state_d == S_HALTED);
    cpu_run_d   = (state_d == S_RUN) || (state_d == S_IN_WAIT) ||
                  (state_d == S_OUT_DRIVE);
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before this edge, independent of statement order.
    if (wb_rst_i) begin
      addr_s1      <= 1'b0;
      addr_s2      <= 1'b0;
      addr_s3      <= 1'b0;
      data_s1      <= 1'b0;
      data_s2      <= 1'b0;
      data_s3      <= 1'b0;
      bus_s1       <= '0;
      bus_s2       <= '0;
      state        <= S_LOAD;
      addr_reg     <= '0;
      idle_cnt     <= '0;
      loaded       <= 1'b0;
      hs_cnt       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pad_data_out <= '0;
      cpu_in_data  <= '0;
      cpu_in_valid <= 1'b0;
      cpu_out_ack  <= 1'b0;
      pad_read     <= 1'b0;
      pad_write    <= 1'b0;
      pad_halt     <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      addr_s1      <= pad_pgrm_addr;
      addr_s2      <= addr_s1;
      addr_s3      <= addr_s2;
      data_s1      <= pad_pgrm_data;
      data_s2      <= data_s1;
      data_s3      <= data_s2;
      bus_s1       <= pad_data_in;
      bus_s2       <= bus_s1;
      state        <= state_d;
      addr_reg     <= addr_d;
      idle_cnt     <= idle_d;
      loaded       <= loaded_d;
      hs_cnt       <= hs_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      pad_data_out <= pad_data_out_d;
      cpu_in_data  <= cpu_in_data_d;
      cpu_in_valid <= cpu_in_valid_d;
      cpu_out_ack  <= cpu_out_ack_d;
      pad_read     <= pad_read_d;
      pad_write    <= pad_write_d;
      pad_halt     <= pad_halt_d;
      cpu_run      <= cpu_run_d;
    end
  end

endmodule

// File: tb/tb_hmmm_pad_bridge.sv
// Directed bench for hmmm_pad_bridge: reset values, program load with
// address wrap and simultaneous strobes, start-delay timing, input and output
// handshakes, request priority, halt, and reset during an output.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_hmmm_pad_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_pgrm_addr, pad_pgrm_data;
  logic [15:0] pad_data_in, pad_data_out, pad_data_oeb;
  logic        pad_read, pad_write, pad_halt;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        cpu_in_req, cpu_in_valid;
  logic [15:0] cpu_in_data;
  logic        cpu_out_req, cpu_out_ack;
  logic [15:0] cpu_out_data;
  logic        cpu_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hmmm_pad_bridge dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .pad_pgrm_addr (pad_pgrm_addr),
    .pad_pgrm_data (pad_pgrm_data),
    .pad_data_in   (pad_data_in),
    .pad_data_out  (pad_data_out),
    .pad_data_oeb  (pad_data_oeb),
    .pad_read      (pad_read),
    .pad_write     (pad_write),
    .pad_halt      (pad_halt),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_run       (cpu_run),
    .cpu_in_req    (cpu_in_req),
    .cpu_in_data   (cpu_in_data),
    .cpu_in_valid  (cpu_in_valid),
    .cpu_out_req   (cpu_out_req),
    .cpu_out_data  (cpu_out_data),
    .cpu_out_ack   (cpu_out_ack),
    .cpu_halted    (cpu_halted)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data strobe high for one clock; detection is two edges after the first
  // sampling edge, and mem_we shows in the cycle after detection.
  task automatic data_strobe(input logic [15:0] value, input logic [7:0] exp_addr,
                             input string tag);
    pad_data_in   = value;
    pad_pgrm_data = 1'b1;
    tick(1);
    pad_data_in   = value;
    pad_pgrm_data = 1'b0;
    tick(1);
    check({tag, "_we_early"}, 32'(mem_we), 32'd0);
    tick(1);
    check({tag, "_we"},    32'(mem_we),    32'd1);
    check({tag, "_addr"},  32'(mem_addr),  32'(exp_addr));
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(value));
    tick(1);
    check({tag, "_we_off"}, 32'(mem_we), 32'd0);
  endtask

  task automatic addr_strobe(input logic [15:0] value);
    pad_data_in   = value;
    pad_pgrm_addr = 1'b1;
    tick(1);
    pad_pgrm_addr = 1'b0;
    tick(3);
    check("addr_only_no_we", 32'(mem_we), 32'd0);
  endtask

  // From the cycle after detection (where data_strobe returns), cpu_run
  // must rise exactly IDLE_CYCLES=32 edges after the detecting edge.
  task automatic check_start(input string tag);
    tick(30);
    check({tag, "_run_before"}, 32'(cpu_run), 32'd0);
    tick(1);
    check({tag, "_run_at"}, 32'(cpu_run), 32'd1);
  endtask

  initial begin
    int ack_cnt;
    logic run_seen;

    rst           = 1'b1;
    pad_pgrm_addr = 1'b0;
    pad_pgrm_data = 1'b0;
    pad_data_in   = 16'h0000;
    cpu_in_req    = 1'b0;
    cpu_out_req   = 1'b0;
    cpu_out_data  = 16'h0000;
    cpu_halted    = 1'b0;

    // Reset values
    tick(3);
    check("rst_data_out",  32'(pad_data_out), 32'h0);
    check("rst_oeb",       32'(pad_data_oeb), 32'hFFFF);
    check("rst_read",      32'(pad_read),     32'h0);
    check("rst_write",     32'(pad_write),    32'h0);
    check("rst_halt",      32'(pad_halt),     32'h0);
    check("rst_mem_we",    32'(mem_we),       32'h0);
    check("rst_mem_addr",  32'(mem_addr),     32'h0);
    check("rst_mem_wdata", 32'(mem_wdata),    32'h0);
    check("rst_run",       32'(cpu_run),      32'h0);
    check("rst_in_data",   32'(cpu_in_data),  32'h0);
    check("rst_in_valid",  32'(cpu_in_valid), 32'h0);
    check("rst_out_ack",   32'(cpu_out_ack),  32'h0);
    rst = 1'b0;

    // No writes yet: the core must never start
    run_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      run_seen = run_seen | cpu_run;
    end
    check("no_write_no_run", 32'(run_seen), 32'd0);

    data_strobe(16'hAAAA, 8'h00, "rst_wr");

    // Program load with auto-increment
    addr_strobe(16'h0000);
    data_strobe(16'h1F64, 8'h00, "load0");
    data_strobe(16'h0101, 8'h01, "load1");

    // Address wrap
    addr_strobe(16'h00FF);
    data_strobe(16'hB7E0, 8'hFF, "wrap_ff");
    data_strobe(16'h0D02, 8'h00, "wrap_00");

    // Address and data strobe in the same cycle: write goes to new address
    pad_data_in   = 16'h1234;
    pad_pgrm_addr = 1'b1;
    pad_pgrm_data = 1'b1;
    tick(1);
    pad_pgrm_addr = 1'b0;
    pad_pgrm_data = 1'b0;
    tick(2);
    check("both_we",    32'(mem_we),    32'd1);
    check("both_addr",  32'(mem_addr),  32'h34);
    check("both_wdata", 32'(mem_wdata), 32'h1234);
    tick(1);
    data_strobe(16'h5555, 8'h35, "both_next");

    // A strobe 20 cycles into the idle count restarts it
    tick(19);
    check("restart_run_low", 32'(cpu_run), 32'd0);
    data_strobe(16'h7777, 8'h36, "restart");
    pad_data_in = 16'h002A;
    check_start("start");

    // Input handshake, with a simultaneous output request losing priority
    cpu_in_req   = 1'b1;
    cpu_out_req  = 1'b1;
    cpu_out_data = 16'hDEAD;
    tick(1);
    check("in_read_hi",  32'(pad_read),     32'd1);
    check("in_prio_wr",  32'(pad_write),    32'd0);
    check("in_oeb",      32'(pad_data_oeb), 32'hFFFF);
    cpu_out_req = 1'b0;
    tick(3);
    check("in_read_hold", 32'(pad_read),     32'd1);
    check("in_no_valid",  32'(cpu_in_valid), 32'd0);
    tick(1);
    check("in_valid",     32'(cpu_in_valid), 32'd1);
    check("in_data",      32'(cpu_in_data),  32'h002A);
    check("in_read_drop", 32'(pad_read),     32'd0);
    cpu_in_req = 1'b0;
    tick(1);
    check("in_valid_off", 32'(cpu_in_valid), 32'd0);
    check("in_run",       32'(cpu_run),      32'd1);

    // Output handshake: four drive cycles, ack on the last
    cpu_out_data = 16'h0115;
    cpu_out_req  = 1'b1;
    ack_cnt      = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      cpu_out_data = 16'hFFFF;
      check("out_write",    32'(pad_write),    32'd1);
      check("out_oeb",      32'(pad_data_oeb), 32'h0000);
      check("out_data",     32'(pad_data_out), 32'h0115);
      check("out_no_read",  32'(pad_read),     32'd0);
      if (cpu_out_ack) begin
        ack_cnt++;
        check("out_ack_pos", 32'(i), 32'd3);
        cpu_out_req = 1'b0;
      end
    end
    tick(1);
    check("out_write_off", 32'(pad_write),    32'd0);
    check("out_oeb_off",   32'(pad_data_oeb), 32'hFFFF);
    check("out_ack_off",   32'(cpu_out_ack),  32'd0);
    check("out_ack_count", 32'(ack_cnt),      32'd1);
    cpu_out_req = 1'b0;
    tick(2);

    // Strobes are ignored while running
    pad_data_in   = 16'h4444;
    pad_pgrm_data = 1'b1;
    tick(1);
    pad_pgrm_data = 1'b0;
    run_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      run_seen = run_seen | mem_we;
    end
    check("run_strobe_ignored", 32'(run_seen), 32'd0);

    // Reset in the middle of an output
    cpu_out_data = 16'h0222;
    cpu_out_req  = 1'b1;
    tick(1);
    check("mid_write", 32'(pad_write), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_oeb",   32'(pad_data_oeb), 32'hFFFF);
    check("mid_rst_write", 32'(pad_write),    32'd0);
    check("mid_rst_run",   32'(cpu_run),      32'd0);
    check("mid_rst_ack",   32'(cpu_out_ack),  32'd0);
    check("mid_rst_dout",  32'(pad_data_out), 32'h0);
    rst         = 1'b0;
    cpu_out_req = 1'b0;
    tick(1);
    data_strobe(16'h3333, 8'h00, "after_rst");
    check_start("restart2");

    // Halt beats a concurrent input request and is sticky
    check("halt_low", 32'(pad_halt), 32'd0);
    cpu_halted = 1'b1;
    cpu_in_req = 1'b1;
    tick(1);
    check("halt_hi",      32'(pad_halt), 32'd1);
    check("halt_run_off", 32'(cpu_run),  32'd0);
    check("halt_no_read", 32'(pad_read), 32'd0);
    cpu_halted = 1'b0;
    tick(10);
    check("halt_sticky",       32'(pad_halt),     32'd1);
    check("halt_sticky_read",  32'(pad_read),     32'd0);
    check("halt_sticky_oeb",   32'(pad_data_oeb), 32'hFFFF);
    check("halt_sticky_run",   32'(cpu_run),      32'd0);
    cpu_in_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
